// File: rtl/round_sequencer.sv
// round_sequencer: game-level controller that sequences play rounds.
//
// Each round is armed in PLAY and ends on a hit (B & FL & ~OB), an
// out-of-bounds ball (B & OB) or a tick timeout. A PAUSE of dead time
// follows every round that does not end the game. The score counter is
// driven with one-cycle score_pulse / clear_score strobes. Lives, win and
// loss are tracked here.
//
// Optional build macro BONUS_LIFE_EN: when defined, three consecutive hits
// restore one life (capped at LIVES). When undefined, lives only decrease.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        single-cycle start/restart request (already synchronised)
//   tick         one-cycle timebase enable; timers advance only on tick
//   B, FL, OB    ball present / ball on floor target / ball out of bounds
//   score_pulse  one-cycle increment strobe to the score counter
//   clear_score  one-cycle reset strobe to the score counter
//   round_active high while in PLAY
//   round_num    hits so far this game
//   lives_left   remaining lives
//   game_won     sticky while in WON
//   game_over    sticky while in LOST
// All outputs are registered.

module round_sequencer #(
  parameter int unsigned WIN_ROUNDS  = 7,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned ROUND_TICKS = 16,
  parameter int unsigned PAUSE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic       B,
  input  logic       FL,
  input  logic       OB,
  output logic       score_pulse,
  output logic       clear_score,
  output logic       round_active,
  output logic [2:0] round_num,
  output logic [1:0] lives_left,
  output logic       game_won,
  output logic       game_over
);

  localparam int unsigned MAX_TICKS = (ROUND_TICKS > PAUSE_TICKS) ? ROUND_TICKS : PAUSE_TICKS;
  localparam int unsigned TW        = $clog2(MAX_TICKS) + 1;

  localparam logic [TW-1:0] ROUND_LAST = TW'(ROUND_TICKS - 1);
  localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_TICKS - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [2:0]    WIN_NUM    = 3'(WIN_ROUNDS);
  localparam logic [1:0]    LIVES_NUM  = 2'(LIVES);

  typedef enum logic [2:0] {
    StIdle,
    StPlay,
    StPause,
    StWon,
    StLost
  } state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;

`ifdef BONUS_LIFE_EN
  logic [1:0] streak_q;
`endif

  logic       hit;
  logic       miss;
  logic [2:0] round_inc;
  logic [1:0] lives_dec;

  assign hit  = B & FL & ~OB;
  assign miss = (B & OB) | (tick & (timer_q == ROUND_LAST));

  // Saturating round count and non-underflowing lives.
  assign round_inc = (round_num == WIN_NUM) ? round_num : round_num + 3'd1;
  assign lives_dec = (lives_left == 2'd0) ? 2'd0 : lives_left - 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      score_pulse  <= 1'b0;
      clear_score  <= 1'b0;
      round_active <= 1'b0;
      round_num    <= 3'd0;
      lives_left   <= LIVES_NUM;
      game_won     <= 1'b0;
      game_over    <= 1'b0;
`ifdef BONUS_LIFE_EN
      streak_q     <= 2'd0;
`endif
    end else begin
      // Strobes default low so each fires for exactly one cycle.
      score_pulse <= 1'b0;
      clear_score <= 1'b0;

      unique case (state_q)
        StIdle, StWon, StLost: begin
          if (start) begin
            state_q      <= StPlay;
            timer_q      <= '0;
            clear_score  <= 1'b1;
            round_active <= 1'b1;
            round_num    <= 3'd0;
            lives_left   <= LIVES_NUM;
            game_won     <= 1'b0;
            game_over    <= 1'b0;
`ifdef BONUS_LIFE_EN
            streak_q     <= 2'd0;
`endif
          end
        end

        StPlay: begin
          if (tick) begin
            timer_q <= timer_q + TIMER_ONE;
          end
          // Hit wins over a simultaneous timeout or out-of-bounds.
          if (hit) begin
            score_pulse  <= 1'b1;
            round_num    <= round_inc;
            timer_q      <= '0;
            round_active <= 1'b0;
`ifdef BONUS_LIFE_EN
            if (streak_q == 2'd2) begin
              streak_q <= 2'd0;
              if (lives_left != LIVES_NUM) begin
                lives_left <= lives_left + 2'd1;
              end
            end else begin
              streak_q <= streak_q + 2'd1;
            end
`endif
            if (round_inc == WIN_NUM) begin
              state_q  <= StWon;
              game_won <= 1'b1;
            end else begin
              state_q <= StPause;
            end
          end else if (miss) begin
            lives_left   <= lives_dec;
            timer_q      <= '0;
            round_active <= 1'b0;
`ifdef BONUS_LIFE_EN
            streak_q     <= 2'd0;
`endif
            if (lives_dec == 2'd0) begin
              state_q   <= StLost;
              game_over <= 1'b1;
            end else begin
              state_q <= StPause;
            end
          end
        end

        StPause: begin
          // Ball inputs and start are ignored; the pause only counts ticks.
          if (tick) begin
            if (timer_q == PAUSE_LAST) begin
              state_q      <= StPlay;
              timer_q      <= '0;
              round_active <= 1'b1;
            end else begin
              timer_q <= timer_q + TIMER_ONE;
            end
          end
        end

        default: begin
          state_q      <= StIdle;
          timer_q      <= '0;
          round_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer (ROUND_TICKS=4, PAUSE_TICKS=2, tick high).
// Stimulus pushes the expected output snapshot for every strobe or change of
// round_num/lives_left/game_won/game_over; a monitor pops and compares.

module tb_round_sequencer;

  localparam int unsigned WIN_ROUNDS  = 7;
  localparam int unsigned LIVES       = 3;
  localparam int unsigned ROUND_TICKS = 4;
  localparam int unsigned PAUSE_TICKS = 2;

`ifdef BONUS_LIFE_EN
  localparam logic [1:0] BONUS_LL = 2'd3;
`else
  localparam logic [1:0] BONUS_LL = 2'd2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b1;
  logic       B = 1'b0;
  logic       FL = 1'b0;
  logic       OB = 1'b0;
  logic       score_pulse;
  logic       clear_score;
  logic       round_active;
  logic [2:0] round_num;
  logic [1:0] lives_left;
  logic       game_won;
  logic       game_over;

  round_sequencer #(
    .WIN_ROUNDS (WIN_ROUNDS),
    .LIVES      (LIVES),
    .ROUND_TICKS(ROUND_TICKS),
    .PAUSE_TICKS(PAUSE_TICKS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .tick        (tick),
    .B           (B),
    .FL          (FL),
    .OB          (OB),
    .score_pulse (score_pulse),
    .clear_score (clear_score),
    .round_active(round_active),
    .round_num   (round_num),
    .lives_left  (lives_left),
    .game_won    (game_won),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sp;
    logic       cs;
    logic [2:0] rn;
    logic [1:0] ll;
    logic       gw;
    logic       go;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  function automatic snap_t mk(input logic sp, input logic cs, input logic [2:0] rn,
                               input logic [1:0] ll, input logic gw, input logic go);
    snap_t s;
    s.sp = sp;
    s.cs = cs;
    s.rn = rn;
    s.ll = ll;
    s.gw = gw;
    s.go = go;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input string name, input snap_t s);
    exp_q.push_back(s);
    name_q.push_back(name);
  endtask

  // Monitor: an event is any strobe or any change of the count/flag fields.
  initial begin
    snap_t      cur;
    snap_t      e;
    string      n;
    logic [6:0] prev_cnt;
    prev_cnt = {3'd0, 2'd3, 1'b0, 1'b0};
    forever begin
      @(negedge clk);
      cur = {score_pulse, clear_score, round_num, lives_left, game_won, game_over};
      if (cur.sp || cur.cs || ({cur.rn, cur.ll, cur.gw, cur.go} != prev_cnt)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got %h required no event", cur);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check(n, 32'(cur), 32'(e));
        end
      end
      prev_cnt = {cur.rn, cur.ll, cur.gw, cur.go};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; after return we sit at the negedge just after the
  // start edge, i.e. state PLAY with timer 0.
  task automatic do_start(input snap_t e, input string name);
    push(name, e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_round_active"}, 32'(round_active), 32'd1);
    check({name, "_clear_score"}, 32'(clear_score), 32'd1);
  endtask

  // Waits delay edges in PLAY, then presents a hit held across the pause.
  task automatic do_hit(input int delay, input logic last, input snap_t e, input string name);
    repeat (delay) @(negedge clk);
    push(name, e);
    B  = 1'b1;
    FL = 1'b1;
    OB = 1'b0;
    @(negedge clk);
    check({name, "_ra_after_hit"}, 32'(round_active), 32'd0);
    @(negedge clk);
    check({name, "_ra_pause"}, 32'(round_active), 32'd0);
    @(negedge clk);
    check({name, "_ra_next"}, 32'(round_active), last ? 32'd0 : 32'd1);
    B  = 1'b0;
    FL = 1'b0;
  endtask

  // Idle in PLAY until the round times out.
  task automatic do_miss(input logic last, input snap_t e, input string name);
    push(name, e);
    B  = 1'b0;
    FL = 1'b0;
    OB = 1'b0;
    repeat (3) @(negedge clk);
    check({name, "_ra_timer3"}, 32'(round_active), 32'd1);
    @(negedge clk);
    check({name, "_ra_after_miss"}, 32'(round_active), 32'd0);
    if (!last) begin
      repeat (2) @(negedge clk);
      check({name, "_ra_next"}, 32'(round_active), 32'd1);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({score_pulse, clear_score, round_active, round_num, lives_left, game_won, game_over}),
          32'({1'b0, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0, 1'b0}));
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_round", 32'(round_active), 32'd0);

    // Game 1: one hit, then three timeouts to a loss.
    do_start(mk(0, 1, 3'd0, 2'd3, 0, 0), "g1_start");
    do_hit(0, 1'b0, mk(1, 0, 3'd1, 2'd3, 0, 0), "g1_hit1");
    do_miss(1'b0, mk(0, 0, 3'd1, 2'd2, 0, 0), "g1_miss1");
    do_miss(1'b0, mk(0, 0, 3'd1, 2'd1, 0, 0), "g1_miss2");
    do_miss(1'b1, mk(0, 0, 3'd1, 2'd0, 0, 1), "g1_miss3");
    B  = 1'b1;
    FL = 1'b1;
    repeat (5) @(negedge clk);
    B  = 1'b0;
    FL = 1'b0;
    check("lost_hold", 32'({game_over, lives_left, round_active}), 32'({1'b1, 2'd0, 1'b0}));

    // Game 2: first hit lands together with the timeout, then a clean win.
    do_start(mk(0, 1, 3'd0, 2'd3, 0, 0), "g2_start");
    do_hit(3, 1'b0, mk(1, 0, 3'd1, 2'd3, 0, 0), "g2_hit_vs_timeout");
    for (int k = 2; k <= 6; k++) begin
      do_hit(0, 1'b0, mk(1, 0, 3'(k), 2'd3, 0, 0), "g2_hit");
    end
    do_hit(0, 1'b1, mk(1, 0, 3'd7, 2'd3, 1, 0), "g2_hit7_win");
    B  = 1'b1;
    FL = 1'b1;
    repeat (6) @(negedge clk);
    B  = 1'b0;
    FL = 1'b0;
    check("won_hold", 32'({game_won, round_num, score_pulse}), 32'({1'b1, 3'd7, 1'b0}));

    // Game 3: reset asserted during the pause after a hit.
    do_start(mk(0, 1, 3'd0, 2'd3, 0, 0), "g3_start");
    push("g3_hit", mk(1, 0, 3'd1, 2'd3, 0, 0));
    B  = 1'b1;
    FL = 1'b1;
    @(negedge clk);
    B  = 1'b0;
    FL = 1'b0;
    push("g3_reset", mk(0, 0, 3'd0, 2'd3, 0, 0));
    #2 reset = 1'b1;
    #1;
    check("g3_reset_immediate",
          32'({score_pulse, clear_score, round_active, round_num, lives_left, game_won, game_over}),
          32'({1'b0, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0, 1'b0}));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("g3_idle_after_reset", 32'({round_active, clear_score}), 32'd0);

    // Game 4: out-of-bounds miss (hit blocked by OB), then three hits.
    do_start(mk(0, 1, 3'd0, 2'd3, 0, 0), "g4_start");
    push("g4_ob_miss", mk(0, 0, 3'd0, 2'd2, 0, 0));
    B  = 1'b1;
    FL = 1'b1;
    OB = 1'b1;
    @(negedge clk);
    B  = 1'b0;
    FL = 1'b0;
    OB = 1'b0;
    check("g4_ra_after_ob", 32'(round_active), 32'd0);
    repeat (2) @(negedge clk);
    check("g4_ra_next", 32'(round_active), 32'd1);
    do_hit(0, 1'b0, mk(1, 0, 3'd1, 2'd2, 0, 0), "g4_hit1");
    do_hit(0, 1'b0, mk(1, 0, 3'd2, 2'd2, 0, 0), "g4_hit2");
    do_hit(0, 1'b0, mk(1, 0, 3'd3, BONUS_LL, 0, 0), "g4_hit3");
    check("g4_lives_final", 32'(lives_left), 32'(BONUS_LL));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Game-level controller that sequences play rounds for the score counter and 7-segment score display.
- Arms a round, then judges the hit condition (B & FL & ~OB) against out-of-bounds and a round timeout.
- Drives the score counter with one-cycle score and clear strobes, and tracks lives, win and loss.
- Sits between the debounced user/sensor inputs and the score counter.

Parameters:
WIN_ROUNDS, 7, hits needed to win (1..7; matches the 3-bit score range)
LIVES, 3, misses allowed before loss (1..3)
ROUND_TICKS, 16, tick pulses allowed per round before timeout (>=2)
PAUSE_TICKS, 4, tick pulses of dead time between rounds (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle, already-synchronised start/restart request
tick  input  1  one-cycle timebase enable; all timers advance only on tick
B  input  1  ball present
FL  input  1  ball on floor target
OB  input  1  ball out of bounds
score_pulse  output  1  one-cycle strobe to the score counter's increment
clear_score  output  1  one-cycle strobe to the score counter's reset
round_active  output  1  high while in PLAY
round_num  output  3  hits so far this game
lives_left  output  2  remaining lives
game_won  output  1  sticky while in WON
game_over  output  1  sticky while in LOST

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock.
- On reset: state=IDLE, all outputs 0, round_num=0, lives_left=LIVES, timer=0.
- All outputs are registered. A condition sampled at edge N is visible after edge N.
- hit = B & FL & ~OB. miss = (B & OB) | (tick & timer==ROUND_TICKS-1).
- States: IDLE, PLAY, PAUSE, WON, LOST.
- IDLE, WON, LOST:
  - On start: go to PLAY; clear_score=1 for exactly one cycle; round_num=0; lives_left=LIVES; timer=0.
  - game_won and game_over drop in the same cycle.
  - Without start: hold. WON and LOST keep their flags and counts.
- PLAY:
  - round_active=1.
  - timer increments on tick.
  - Priority: hit > miss. start is ignored.
  - On hit: score_pulse=1 for one cycle; round_num+1.
    - If the new round_num==WIN_ROUNDS, go to WON.
    - Otherwise go to PAUSE with timer=0.
  - On miss (no hit): lives_left-1.
    - If it reaches 0, go to LOST.
    - Otherwise go to PAUSE with timer=0.
  - A hit and a timeout in the same cycle count as a hit only.
- PAUSE:
  - round_active=0. B/FL/OB and start are ignored.
  - timer increments on tick. After PAUSE_TICKS ticks, go to PLAY with timer=0.
- Strobes:
  - score_pulse fires at most once per round, even if hit stays high; PAUSE separates rounds.
  - score_pulse and clear_score are never high together.
- Arithmetic:
  - round_num saturates at WIN_ROUNDS.
  - lives_left never underflows.
  - timer width is clog2(max(ROUND_TICKS, PAUSE_TICKS))+1.
- Reset asserted mid-round clears everything immediately, with no strobe emitted.

Optional Feature:
- Macro: BONUS_LIFE_EN.
- Defined:
  - A 2-bit streak counter counts consecutive hits and clears on any miss.
  - On the third consecutive hit, lives_left+1 (capped at LIVES) in the same cycle as score_pulse, and the streak clears.
- Undefined: no streak logic; lives only decrease.

Test Plan:
- Bench setup for all scenarios: ROUND_TICKS=4, PAUSE_TICKS=2, tick tied high.
- Reset, then pulse start -> clear_score high for 1 cycle, round_active=1 the cycle after start, lives_left=3, round_num=0.
- In PLAY, hold B=1, FL=1, OB=0 for 5 cycles -> exactly one score_pulse, round_num=1, round_active=0 for 2 cycles, then 1 again.
- Idle in PLAY with B=0 -> timeout after 4 ticks, lives_left 3->2; repeat twice more -> game_over=1, lives_left=0; start -> clear_score, lives_left=3.
- Same cycle: B=1, FL=1, OB=0 and timer==3 -> score_pulse=1, lives_left unchanged.
- 7 clean hits -> game_won=1 after the 7th score_pulse, round_num=7; further hits produce no strobes.
- Assert reset mid-PAUSE -> all outputs 0 immediately, state IDLE; with BONUS_LIFE_EN, miss then 3 hits -> lives_left 2->3.
